// File: rtl/alarm_timer_if.sv
// Alarm timer bus: run enable, raw buttons, delay configuration and the
// observable timer status.
//   master : drives ena, btn_n, clr_n, delay_cfg, snooze_cfg
//   slave  : the timer; drives alarm, state, count, snooze_cnt, press
interface alarm_timer_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             btn_n;
  logic             clr_n;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] snooze_cfg;
  logic             alarm;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [1:0]       snooze_cnt;
  logic             press;

  modport master (
    output ena, btn_n, clr_n, delay_cfg, snooze_cfg,
    input  alarm, state, count, snooze_cnt, press
  );

  modport slave (
    input  ena, btn_n, clr_n, delay_cfg, snooze_cfg,
    output alarm, state, count, snooze_cnt, press
  );
endinterface

// File: rtl/alarm_timer.sv
// Alarm timer with debounced arm/snooze and dismiss buttons.
//   alarm_timer_db : 2-flop synchronizer plus level debouncer for one
//                    active-low button; emits a one-cycle pulse.
//   alarm_timer    : IDLE -> ARMED -> ALERT <-> SNOOZE timer FSM.
// Ports (top):
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave modport) ena, btn_n, clr_n, delay_cfg, snooze_cfg in;
//                       alarm, state, count, snooze_cnt, press out

module alarm_timer_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic pulse
);
  localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  // DB_REARM waits for DB_CYCLES released samples, DB_ARMED for
  // DB_CYCLES pressed samples. Reset lands in DB_REARM so a button held
  // through reset must be released before it can fire.
  typedef enum logic {DB_REARM, DB_ARMED} db_state_t;

  logic [1:0]     sync;
  db_state_t      st, st_nxt;
  logic [DBW-1:0] cnt, cnt_nxt;
  logic           pulse_nxt;
  logic           lvl;

  assign lvl = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '1;
      st    <= DB_REARM;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw_n};
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    unique case (st)
      DB_ARMED: begin
        if (lvl) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          pulse_nxt = 1'b1;
          st_nxt    = DB_REARM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + DBW'(1);
        end
      end
      default: begin
        if (!lvl) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          st_nxt  = DB_ARMED;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + DBW'(1);
        end
      end
    endcase
  end
endmodule

module alarm_timer #(
  parameter int CNT_W         = 8,
  parameter int DB_CYCLES     = 4,
  parameter int SNOOZE_MAX    = 3,
  parameter int ALERT_TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_timer_if.slave bus
);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(ALERT_TIMEOUT);
  localparam logic [1:0]       SN_MAX  = 2'(SNOOZE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_ALERT  = 2'b10,
    S_SNOOZE = 2'b11
  } state_t;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] dly, dly_nxt;
  logic [CNT_W-1:0] sdly, sdly_nxt;
  logic [1:0]       sc, sc_nxt;
  logic             alarm_q;
  logic             press_p, clr_p;
  logic             press_ev, clr_ev;

  alarm_timer_db #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (bus.btn_n),
    .pulse (press_p)
  );

  alarm_timer_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (bus.clr_n),
    .pulse (clr_p)
  );

  // Debouncers free-run; their pulses only count while enabled.
  assign press_ev = press_p & bus.ena;
  assign clr_ev   = clr_p & bus.ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      cnt     <= '0;
      dly     <= '0;
      sdly    <= '0;
      sc      <= '0;
      alarm_q <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      dly     <= dly_nxt;
      sdly    <= sdly_nxt;
      sc      <= sc_nxt;
      alarm_q <= (st_nxt == S_ALERT);
    end
  end

  // Within each state, clr is tested before press and both before the
  // phase compare, which gives clr > press > timeout priority.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    dly_nxt  = dly;
    sdly_nxt = sdly;
    sc_nxt   = sc;
    if (bus.ena) begin
      unique case (st)
        S_IDLE: begin
          if (!clr_ev && press_ev) begin
            st_nxt  = S_ARMED;
            cnt_nxt = '0;
            dly_nxt = bus.delay_cfg;
            sc_nxt  = '0;
          end
        end
        S_ARMED: begin
          if (clr_ev || press_ev) begin
            st_nxt  = S_IDLE;
            cnt_nxt = '0;
          end else if (cnt == dly) begin
            st_nxt  = S_ALERT;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_ALERT: begin
          if (clr_ev) begin
            st_nxt  = S_IDLE;
            cnt_nxt = '0;
          end else if (press_ev && (sc < SN_MAX)) begin
            st_nxt   = S_SNOOZE;
            sc_nxt   = sc + 2'd1;
            sdly_nxt = bus.snooze_cfg;
            cnt_nxt  = '0;
          end else if (cnt == TIMEOUT) begin
            // An exhausted-snooze press is a no-op, so the timeout still applies.
            st_nxt  = S_IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_SNOOZE: begin
          if (clr_ev) begin
            st_nxt  = S_IDLE;
            cnt_nxt = '0;
          end else if (cnt == sdly) begin
            st_nxt  = S_ALERT;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          st_nxt  = S_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  assign bus.alarm      = alarm_q;
  assign bus.state      = st;
  assign bus.count      = cnt;
  assign bus.snooze_cnt = sc;
  assign bus.press      = press_p;
endmodule

// File: tb/tb_alarm_timer.sv
module tb_alarm_timer;
  localparam int CNT_W = 8;
  localparam int DB    = 4;
  localparam int SMAX  = 3;
  localparam int TO    = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_timer_if #(.CNT_W(CNT_W)) bus ();

  alarm_timer #(
    .CNT_W         (CNT_W),
    .DB_CYCLES     (DB),
    .SNOOZE_MAX    (SMAX),
    .ALERT_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int press_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 armed, 2 alert, 3 snooze. Buttons are modelled as
  // run lengths of the 2-sample-delayed raw level.
  int  m_state, m_count, m_sc, m_dly, m_sdly;
  bit  m_press, m_clr;
  bit  bh [2];
  bit  ch [2];
  int  blo, bhi, clo, chi;
  bit  brdy, crdy;

  task automatic m_reset();
    m_state = 0; m_count = 0; m_sc = 0; m_dly = 0; m_sdly = 0;
    m_press = 0; m_clr = 0;
    bh[0] = 1; bh[1] = 1; ch[0] = 1; ch[1] = 1;
    blo = 0; bhi = 0; clo = 0; chi = 0; brdy = 0; crdy = 0;
  endtask

  task automatic db(input bit s, inout int lo, inout int hi, inout bit rdy, output bit pulse);
    pulse = 0;
    if (!s) begin
      hi = 0;
      if (lo < DB) lo++;
      if (lo == DB && rdy) begin pulse = 1; rdy = 0; end
    end else begin
      lo = 0;
      if (hi < DB) begin
        hi++;
        if (hi == DB) rdy = 1;
      end
    end
  endtask

  task automatic m_step();
    bit p, c, pn, cn;
    p = m_press && bus.ena;
    c = m_clr && bus.ena;
    if (bus.ena) begin
      case (m_state)
        0: if (!c && p) begin m_state = 1; m_count = 0; m_dly = int'(bus.delay_cfg); m_sc = 0; end
        1: if (c || p) begin m_state = 0; m_count = 0; end
           else if (m_count == m_dly) begin m_state = 2; m_count = 0; end
           else m_count++;
        2: if (c) begin m_state = 0; m_count = 0; end
           else if (p && m_sc < SMAX) begin
             m_state = 3; m_sc++; m_sdly = int'(bus.snooze_cfg); m_count = 0;
           end
           else if (m_count == TO) begin m_state = 0; m_count = 0; end
           else m_count++;
        default: if (c) begin m_state = 0; m_count = 0; end
           else if (m_count == m_sdly) begin m_state = 2; m_count = 0; end
           else m_count++;
      endcase
    end
    db(bh[1], blo, bhi, brdy, pn);
    db(ch[1], clo, chi, crdy, cn);
    bh[1] = bh[0]; bh[0] = bus.btn_n;
    ch[1] = ch[0]; ch[0] = bus.clr_n;
    m_press = pn;
    m_clr   = cn;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("state", 32'(bus.state), m_state);
      chk("alarm", 32'(bus.alarm), (m_state == 2) ? 1 : 0);
      chk("count", 32'(bus.count), m_count);
      chk("snooze_cnt", 32'(bus.snooze_cnt), m_sc);
      chk("press", 32'(bus.press), m_press);
      if (bus.press === 1'b1) press_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic btn_pulse(input int lo, input int hi);
    bus.btn_n = 0; cyc(lo); bus.btn_n = 1; cyc(hi);
  endtask

  task automatic clr_pulse(input int lo, input int hi);
    bus.clr_n = 0; cyc(lo); bus.clr_n = 1; cyc(hi);
  endtask

  task automatic both_pulse(input int lo, input int hi);
    bus.btn_n = 0; bus.clr_n = 0; cyc(lo);
    bus.btn_n = 1; bus.clr_n = 1; cyc(hi);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_alarm"}, 32'(bus.alarm), 0);
    chk({tag, "_sc"}, 32'(bus.snooze_cnt), 0);
    chk({tag, "_press"}, 32'(bus.press), 0);
  endtask

  initial begin
    int first, armed_n, alert_n, p0, hold_b, hold_c;
    bus.ena = 1; bus.btn_n = 1; bus.clr_n = 1;
    bus.delay_cfg = 8'd5; bus.snooze_cfg = 8'd2;
    cyc(3);
    chk_reset_outputs("rst");
    rst_n = 1;
    cyc(10);

    // Arm with delay 5: press latency, ARMED length, then ALERT.
    bus.btn_n = 0;
    first = -1; armed_n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.press === 1'b1 && first < 0) first = k;
      if (bus.state == 2'b01) armed_n++;
      if (k == 10) bus.btn_n = 1;
    end
    chk("press_latency", first, 6);
    chk("armed_cycles", armed_n, 6);
    chk("alert_state", 32'(bus.state), 2);
    chk("alert_alarm", 32'(bus.alarm), 1);
    clr_pulse(6, 6);
    chk("clr_idle", 32'(bus.state), 0);

    // Short glitches never produce a press.
    p0 = press_seen;
    btn_pulse(3, 8);
    btn_pulse(1, 8);
    chk("glitch_press", press_seen - p0, 0);
    chk("glitch_idle", 32'(bus.state), 0);

    // Snooze budget: three snoozes, fourth press ignored, then clr.
    bus.delay_cfg = 8'd0; bus.snooze_cfg = 8'd2;
    btn_pulse(6, 6);
    chk("snz_alert0", 32'(bus.state), 2);
    for (int i = 1; i <= 4; i++) begin
      btn_pulse(6, 10);
      chk("snz_cnt", 32'(bus.snooze_cnt), (i < 3) ? i : 3);
      chk("snz_alert", 32'(bus.state), 2);
    end
    clr_pulse(6, 6);
    chk("snz_clr_state", 32'(bus.state), 0);
    chk("snz_clr_alarm", 32'(bus.alarm), 0);
    chk("snz_hold_cnt", 32'(bus.snooze_cnt), 3);

    // Alert auto-dismiss after 201 cycles.
    btn_pulse(6, 1);
    alert_n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.state == 2'b10) alert_n++;
      else if (alert_n > 0) break;
    end
    chk("alert_cycles", alert_n, 201);
    chk("timeout_state", 32'(bus.state), 0);
    chk("timeout_alarm", 32'(bus.alarm), 0);

    // clr and press in the same ALERT cycle: clr wins.
    btn_pulse(6, 6);
    btn_pulse(6, 10);
    chk("both_pre_sc", 32'(bus.snooze_cnt), 1);
    both_pulse(6, 8);
    chk("both_state", 32'(bus.state), 0);
    chk("both_sc", 32'(bus.snooze_cnt), 1);

    // Asynchronous reset mid-SNOOZE with a button held through it.
    bus.snooze_cfg = 8'd100;
    btn_pulse(6, 6);
    btn_pulse(6, 4);
    chk("pre_rst_snooze", 32'(bus.state), 3);
    bus.btn_n = 0;
    cyc(8);
    @(posedge clk);
    #2;
    bus.ena = 0;
    rst_n = 0;
    #1;
    chk_reset_outputs("async");
    cyc(2);
    rst_n = 1;
    bus.ena = 1;
    p0 = press_seen;
    cyc(20);
    chk("held_no_press", press_seen - p0, 0);
    bus.btn_n = 1;
    cyc(4);
    bus.btn_n = 0;
    p0 = press_seen;
    cyc(8);
    chk("repress", press_seen - p0, 1);
    bus.btn_n = 1;
    cyc(10);

    // Randomized traffic against the model.
    hold_b = 5; hold_c = 50;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (hold_b == 0) begin
        bus.btn_n = ~bus.btn_n;
        hold_b = bus.btn_n ? int'($urandom_range(4, 40)) : int'($urandom_range(1, 10));
      end else hold_b--;
      if (hold_c == 0) begin
        bus.clr_n = ~bus.clr_n;
        hold_c = bus.clr_n ? int'($urandom_range(20, 150)) : int'($urandom_range(1, 8));
      end else hold_c--;
      bus.ena = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) bus.delay_cfg = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 31) == 0) bus.snooze_cfg = 8'($urandom_range(0, 20));
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 999) == 0) rst_n = 0;
    end
    rst_n = 1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
